// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: EX/MEM-side inputs and MEM/WB register outputs of the memory stage.
interface mem_wb_stage_if;
  logic        stall;
  logic        flush;
  logic        MemRead;
  logic        MemWrite;
  logic        MemtoReg;
  logic        RegWrite;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] address;
  logic [31:0] writeDataIn;
  logic [4:0]  writeReg;
  logic [31:0] data_out;
  logic [31:0] address_out;
  logic        MemtoReg_out;
  logic        RegWrite_out;
  logic [4:0]  writeReg_out;
  logic        misaligned;
  modport master (
    output stall, flush, MemRead, MemWrite, MemtoReg, RegWrite, mem_size, mem_unsigned,
           address, writeDataIn, writeReg,
    input  data_out, address_out, MemtoReg_out, RegWrite_out, writeReg_out, misaligned
  );
  modport slave (
    input  stall, flush, MemRead, MemWrite, MemtoReg, RegWrite, mem_size, mem_unsigned,
           address, writeDataIn, writeReg,
    output data_out, address_out, MemtoReg_out, RegWrite_out, writeReg_out, misaligned
  );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: big-endian data memory with sized loads/stores and the MEM/WB pipeline register.
module mem_wb_stage #(
  parameter int ADDR_W = 8
) (
  input logic           clk,
  input logic           reset,
  mem_wb_stage_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [31:0] mem_q [DEPTH] = '{default: '0};
  logic [ADDR_W-1:0] idx;
  logic [1:0]  off;
  logic        is_half, is_word, fault, store_en;
  logic [3:0]  lane_en;
  logic [31:0] rd_word, lane_mask, wr_data, load_ext, load_val;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] data_d, data_q, addr_d, addr_q;
  logic        m2r_d, m2r_q, rw_d, rw_q, mis_d, mis_q;
  logic [4:0]  wreg_d, wreg_q;
  assign idx      = bus.address[ADDR_W+1:2];
  assign off      = bus.address[1:0];
  assign is_half  = bus.mem_size == 2'b01;
  assign is_word  = bus.mem_size[1];
  assign fault    = (bus.MemRead | bus.MemWrite) & ((is_half & off[0]) | (is_word & |off));
  assign store_en = bus.MemWrite & ~fault & ~bus.stall & ~bus.flush & ~reset;
  assign rd_word  = mem_q[idx];
  always_comb begin
    byte_sel  = off == 2'd0 ? rd_word[31:24] : off == 2'd1 ? rd_word[23:16] :
                off == 2'd2 ? rd_word[15:8]  : rd_word[7:0];
    half_sel  = off[1] ? rd_word[15:0] : rd_word[31:16];
    load_ext  = is_word ? rd_word :
                is_half ? {{16{~bus.mem_unsigned & half_sel[15]}}, half_sel} :
                          {{24{~bus.mem_unsigned & byte_sel[7]}}, byte_sel};
    load_val  = (bus.MemRead & ~fault) ? load_ext : 32'd0;
    lane_en   = is_word ? 4'b1111 : is_half ? (off[1] ? 4'b0011 : 4'b1100) : 4'b1000 >> off;
    lane_mask = {{8{lane_en[3]}}, {8{lane_en[2]}}, {8{lane_en[1]}}, {8{lane_en[0]}}};
    wr_data   = is_word ? bus.writeDataIn :
                is_half ? {2{bus.writeDataIn[15:0]}} : {4{bus.writeDataIn[7:0]}};
  end
  // Read-modify-write keeps unaddressed lanes; the read port is the same combinational path as loads.
  always_ff @(posedge clk)
    if (store_en) mem_q[idx] <= (rd_word & ~lane_mask) | (wr_data & lane_mask);
  always_comb begin
    data_d = bus.flush ? 32'd0 : bus.stall ? data_q : load_val;
    addr_d = bus.flush ? 32'd0 : bus.stall ? addr_q : bus.address;
    m2r_d  = bus.flush ? 1'b0  : bus.stall ? m2r_q  : bus.MemtoReg;
    rw_d   = bus.flush ? 1'b0  : bus.stall ? rw_q   : bus.RegWrite & ~fault;
    wreg_d = bus.flush ? 5'd0  : bus.stall ? wreg_q : bus.writeReg;
    mis_d  = bus.flush ? 1'b0  : bus.stall ? mis_q  : fault;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      data_q <= '0;
      addr_q <= '0;
      m2r_q  <= 1'b0;
      rw_q   <= 1'b0;
      wreg_q <= '0;
      mis_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      addr_q <= addr_d;
      m2r_q  <= m2r_d;
      rw_q   <= rw_d;
      wreg_q <= wreg_d;
      mis_q  <= mis_d;
    end
  assign bus.data_out     = data_q;
  assign bus.address_out  = addr_q;
  assign bus.MemtoReg_out = m2r_q;
  assign bus.RegWrite_out = rw_q;
  assign bus.writeReg_out = wreg_q;
  assign bus.misaligned   = mis_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench with a byte-addressed reference memory model.
module tb_mem_wb_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mem_wb_stage_if bus();
  mem_wb_stage #(.ADDR_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
    logic        m2r;
    logic        rw;
    logic [4:0]  wreg;
    logic        mis;
  } out_t;
  typedef struct {
    bit stall, flush, rd, wr, m2r, rw, uns;
    bit [1:0]  sz;
    bit [31:0] addr, wd;
    bit [4:0]  wreg;
  } stim_t;

  out_t exp_q[$];
  out_t model_out = '0;
  byte unsigned mem_b [1024];
  int errors = 0;
  int checks = 0;

  function automatic out_t cur();
    return {bus.data_out, bus.address_out, bus.MemtoReg_out, bus.RegWrite_out, bus.writeReg_out, bus.misaligned};
  endfunction

  function automatic stim_t mk(bit rd, bit wr, bit [1:0] sz, bit uns, bit [31:0] addr, bit [31:0] wd,
                               bit m2r, bit rw, bit [4:0] wreg, bit stall = 0, bit flush = 0);
    stim_t s;
    s.rd = rd; s.wr = wr; s.sz = sz; s.uns = uns; s.addr = addr; s.wd = wd;
    s.m2r = m2r; s.rw = rw; s.wreg = wreg; s.stall = stall; s.flush = flush;
    return s;
  endfunction

  task automatic drive_bus(input stim_t s);
    bus.stall = s.stall; bus.flush = s.flush; bus.MemRead = s.rd; bus.MemWrite = s.wr;
    bus.MemtoReg = s.m2r; bus.RegWrite = s.rw; bus.mem_size = s.sz; bus.mem_unsigned = s.uns;
    bus.address = s.addr; bus.writeDataIn = s.wd; bus.writeReg = s.wreg;
  endtask

  task automatic apply(input stim_t s);
    int n, a;
    bit flt;
    bit [31:0] v;
    @(negedge clk);
    drive_bus(s);
    n = s.sz == 2'd0 ? 1 : s.sz == 2'd1 ? 2 : 4;
    a = int'(s.addr[9:0]);
    flt = (s.rd || s.wr) && (a % n != 0);
    v = 0;
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(mem_b[(a + i) % 1024]);
    if (n < 4 && !s.uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    if (s.wr && !flt && !s.stall && !s.flush)
      for (int i = 0; i < n; i++) mem_b[(a + i) % 1024] = 8'(s.wd >> (8*(n-1-i)));
    if (s.flush) model_out = '0;
    else if (!s.stall) model_out = {(s.rd && !flt) ? v : 32'd0, s.addr, s.m2r, s.rw && !flt, s.wreg, flt};
    exp_q.push_back(model_out);
  endtask

  task automatic check_now(input string name, input out_t want);
    out_t got;
    got = cur();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got data=%h addr=%h m2r=%b rw=%b wreg=%0d mis=%b, expected data=%h addr=%h m2r=%b rw=%b wreg=%0d mis=%b",
               name, got.data, got.addr, got.m2r, got.rw, got.wreg, got.mis,
               want.data, want.addr, want.m2r, want.rw, want.wreg, want.mis);
    end
  endtask

  initial begin : monitor
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_now("mem_wb_out", e);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    stim_t s;
    foreach (mem_b[i]) mem_b[i] = 8'd0;
    drive_bus(mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check_now("reset_state", '0);
    reset = 1'b0;
    apply(mk(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0));
    apply(mk(1, 0, 2'd2, 0, 32'h10, 0, 1, 1, 5));
    apply(mk(0, 1, 2'd0, 0, 32'h13, 32'h7F, 0, 0, 0));
    apply(mk(1, 0, 2'd0, 1, 32'h13, 0, 1, 1, 6));
    apply(mk(1, 0, 2'd0, 0, 32'h10, 0, 1, 1, 7));
    apply(mk(1, 0, 2'd2, 0, 32'h10, 0, 1, 1, 8));
    apply(mk(1, 0, 2'd1, 1, 32'h10, 0, 1, 1, 9));
    apply(mk(1, 0, 2'd1, 0, 32'h10, 0, 1, 1, 10));
    apply(mk(1, 0, 2'd1, 0, 32'h12, 0, 1, 1, 11));
    apply(mk(0, 1, 2'd2, 0, 32'h11, 32'h12345678, 0, 1, 12));
    apply(mk(1, 0, 2'd2, 0, 32'h10, 0, 1, 1, 13));
    apply(mk(1, 0, 2'd1, 0, 32'h11, 0, 1, 1, 14));
    apply(mk(0, 1, 2'd2, 0, 32'h20, 32'h11111111, 0, 1, 15, 1, 0));
    apply(mk(1, 0, 2'd2, 0, 32'h20, 0, 1, 1, 16));
    apply(mk(1, 0, 2'd2, 0, 32'h20, 0, 1, 1, 17, 1, 1));
    apply(mk(0, 1, 2'd3, 0, 32'h3FC, 32'hCAFEF00D, 0, 0, 0));
    apply(mk(1, 0, 2'd3, 1, 32'hFFFF_F3FC, 0, 1, 1, 18));
    apply(mk(1, 1, 2'd2, 0, 32'h3FC, 32'h01020304, 1, 1, 19));
    apply(mk(1, 0, 2'd2, 0, 32'h3FC, 0, 1, 1, 20));
    for (int k = 0; k < 400; k++) begin
      int op;
      op = $urandom_range(0, 19);
      s = mk(op < 8 || op == 19, (op >= 8 && op < 16) || op == 19, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 47)),
             $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      apply(s);
    end
    apply(mk(1, 0, 2'd2, 0, 32'h10, 0, 1, 1, 21));
    @(posedge clk);
    #2;
    checks++;
    if (bus.RegWrite_out !== model_out.rw) begin
      errors++;
      $display("FAIL rw_before_reset: got %b expected %b", bus.RegWrite_out, model_out.rw);
    end
    #1;
    reset = 1'b1;
    drive_bus(mk(0, 1, 2'd2, 0, 32'h10, 32'hAAAAAAAA, 1, 1, 22));
    #1;
    model_out = '0;
    check_now("async_reset_clear", '0);
    @(negedge clk);
    reset = 1'b0;
    drive_bus(mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0));
    check_now("reset_held_edge", '0);
    apply(mk(1, 0, 2'd2, 0, 32'h10, 0, 1, 1, 23));
    apply(mk(1, 0, 2'd0, 1, 32'h13, 0, 1, 1, 24));
    apply(mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected outputs never compared, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register for the MIPS pipeline. It sits between the EX/MEM register and the write-back mux, and owns the data memory. It performs word, halfword and byte loads and stores, and sign- or zero-extends load data. On each clock it registers the load data, ALU result and write-back controls that the write-back mux consumes as `data`, `address` and `MemtoReg`.

## Interface
- `ADDR_W`, 8: word-index width; data memory holds 2^ADDR_W 32-bit words.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hold the MEM/WB register and suppress the store.
- `flush`  in  1  insert a bubble into MEM/WB and suppress the store.
- `MemRead`  in  1  load instruction.
- `MemWrite`  in  1  store instruction.
- `MemtoReg`  in  1  write-back source select, passed through.
- `RegWrite`  in  1  register-file write enable, passed through.
- `mem_size`  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- `mem_unsigned`  in  1  loads zero-extend when 1 and sign-extend when 0.
- `address`  in  32  ALU result / effective address.
- `writeDataIn`  in  32  store data (rt); the low byte or low half is used for sb/sh.
- `writeReg`  in  5  destination register number.
- `data_out`  out  32  registered load data, feeding the write-back mux `data` input.
- `address_out`  out  32  registered ALU result, feeding the write-back mux `address` input.
- `MemtoReg_out`  out  1  registered MemtoReg.
- `RegWrite_out`  out  1  registered, qualified RegWrite.
- `writeReg_out`  out  5  registered destination register.
- `misaligned`  out  1  registered alignment-fault flag, 1 cycle per faulting instruction.

## Operation
- Word index is `address[ADDR_W+1:2]`. Higher address bits are ignored, so addresses wrap modulo 2^(ADDR_W+2) bytes.
- Byte lanes are big-endian: `address[1:0]`=0 selects bits 31:24 and 3 selects bits 7:0. Halfword `address[1]`=0 selects 31:16.
- Alignment fault (`fault`):
  - half access with `address[0]`=1;
  - word access with `address[1:0]`≠0;
  - byte accesses never fault;
  - counts only when `MemRead` or `MemWrite` is set.
- Store enable is `MemWrite & ~fault & ~stall & ~flush`. Only the addressed lanes are written; other lanes keep their contents.
- Load data is the selected lane, extended to 32 bits according to `mem_unsigned`. For a word access, `mem_unsigned` is ignored.
- `data_out` is 0 when `MemRead`=0 or `fault`=1.
- MEM/WB update on each edge, in priority order:
  - **flush:** all outputs load 0.
  - **stall:** all outputs hold.
  - **otherwise:**
    - `data_out` takes the load data;
    - `address_out` takes `address`;
    - `MemtoReg_out` takes `MemtoReg`;
    - `RegWrite_out` takes `RegWrite & ~fault`;
    - `writeReg_out` takes `writeReg`;
    - `misaligned` takes `fault`.
- If `flush` and `stall` are both set, `flush` wins.
- `MemRead` and `MemWrite` both set is illegal. The store is performed and `data_out` shows the pre-store contents.
- Reset clears every output to 0. Memory contents are not cleared by `reset` and initialise to 0 at time zero.

## Timing
- Latency from inputs to outputs is 1 cycle. Inputs presented before edge N appear on the outputs after edge N.
- A store is committed at edge N. A load of the same word presented at edge N+1 returns the new data. There is no same-cycle read-after-write, since there is one access per cycle.
- Memory read is combinational from the array into the MEM/WB register, so the pipeline needs no extra stall cycle for loads.
- `misaligned` is high for exactly 1 cycle per faulting instruction. It stays high across a stall, because the register holds.
- An asynchronous `reset` mid-operation:
  - clears the outputs immediately, without waiting for a clock edge;
  - suppresses any store at an edge where `reset` is asserted;
  - leaves stores already committed intact.

## Test plan
- **Word store then load:**
  - Cycle 1: sw with `address`=0x10 and `writeDataIn`=0xDEADBEEF.
  - Cycle 2: lw with `address`=0x10, `MemtoReg`=1, `RegWrite`=1 and `writeReg`=5.
  - Required after edge 2: `data_out`=0xDEADBEEF, `address_out`=0x10, `RegWrite_out`=1 and `writeReg_out`=5.
- **Byte lanes:**
  - First, after the word store above, sb 0x7F to 0x13.
  - lbu 0x13 must give 0x0000007F.
  - lb 0x10 must give 0xFFFFFFDE.
  - lw 0x10 must give 0xDEADBE7F.
- **Halfword extension:**
  - lhu 0x10 must give 0x0000DEAD.
  - lh 0x10 must give 0xFFFFDEAD.
  - lh 0x12 must give 0xFFFFBE7F.
- **Misalignment:**
  - sw to 0x11 with data 0x12345678: `misaligned`=1 for 1 cycle, `RegWrite_out`=0 and the memory is unchanged (lw 0x10 still gives 0xDEADBE7F).
  - lh from 0x11: `data_out`=0 and `misaligned`=1.
- **Stall and flush:**
  - With a sw to 0x20 of 0x11111111 and `stall`=1: the outputs hold their previous values, and a later lw 0x20 returns 0.
  - With `flush`=1 and `stall`=1 on a lw: all outputs go to 0.
- **Async reset:**
  - Assert `reset` mid-cycle while `RegWrite_out`=1: the outputs go to 0 before the next edge.
  - Previously stored 0xDEADBE7F at 0x10 is still readable after reset.
